// File: rtl/avm_avalonmaster_peak.sv
// Avalon-MM master that scans an array of 64-bit magnitudes and writes back a peak record.
// It reads NUM magnitudes (low word at MADDR+8i, high word at +4), tracks the largest value
// and the index where it first appears, and counts values strictly above THRESH. It then
// writes a 3-word record {peak[31:0], peak[63:32], {cnt, idx}} to RESADDR.
//
// Ports:
//   CSI_CLOCK_CLK / CSI_CLOCK_RESET  clock, asynchronous active-low reset
//   START, NUM, MADDR, RESADDR, THRESH  job request, sampled when idle
//   DONE, BUSY                          one-cycle completion pulse, not-idle flag
//   PEAK_VALUE, PEAK_INDEX, ABOVE_CNT   job results, held until the next job starts
//   AVM_AVALONMASTER_*                  Avalon-MM master (read/write with waitrequest)
module avm_avalonmaster_peak #(
  parameter int unsigned AVM_AVALONMASTER_DATA_WIDTH    = 32,
  parameter int unsigned AVM_AVALONMASTER_ADDRESS_WIDTH = 32
) (
  input  logic                                      CSI_CLOCK_CLK,
  input  logic                                      CSI_CLOCK_RESET,
  input  logic                                      START,
  input  logic [10:0]                               NUM,
  input  logic [AVM_AVALONMASTER_ADDRESS_WIDTH-1:0] MADDR,
  input  logic [AVM_AVALONMASTER_ADDRESS_WIDTH-1:0] RESADDR,
  input  logic [63:0]                               THRESH,
  output logic                                      DONE,
  output logic                                      BUSY,
  output logic [63:0]                               PEAK_VALUE,
  output logic [10:0]                               PEAK_INDEX,
  output logic [10:0]                               ABOVE_CNT,
  output logic [AVM_AVALONMASTER_ADDRESS_WIDTH-1:0] AVM_AVALONMASTER_ADDRESS,
  input  logic                                      AVM_AVALONMASTER_WAITREQUEST,
  output logic                                      AVM_AVALONMASTER_READ,
  output logic                                      AVM_AVALONMASTER_WRITE,
  input  logic [AVM_AVALONMASTER_DATA_WIDTH-1:0]    AVM_AVALONMASTER_READDATA,
  output logic [AVM_AVALONMASTER_DATA_WIDTH-1:0]    AVM_AVALONMASTER_WRITEDATA
);

  localparam int unsigned AW = AVM_AVALONMASTER_ADDRESS_WIDTH;
  localparam int unsigned DW = AVM_AVALONMASTER_DATA_WIDTH;

  typedef enum logic [2:0] {
    StIdle, StInit, StRdLo, StRdHi, StWrLo, StWrHi, StWrIdx, StFin
  } state_e;

  state_e          state_q, state_d;
  logic [10:0]     num_q, idx_q, peak_idx_q, above_q;
  logic [AW-1:0]   rd_addr_q, res_addr_q;
  logic [63:0]     thresh_q, peak_q;
  logic [DW-1:0]   lo_q;
  logic [63:0]     mag;
  logic            xfer_done;
  logic            last;

  assign xfer_done = ~AVM_AVALONMASTER_WAITREQUEST;
  assign mag       = {AVM_AVALONMASTER_READDATA, lo_q};
  assign last      = (idx_q == num_q - 11'd1);

  // Bus outputs are decoded from the state so a reset drops them immediately.
  always_comb begin
    state_d                    = state_q;
    AVM_AVALONMASTER_READ      = 1'b0;
    AVM_AVALONMASTER_WRITE     = 1'b0;
    AVM_AVALONMASTER_ADDRESS   = '0;
    AVM_AVALONMASTER_WRITEDATA = '0;
    case (state_q)
      StIdle: if (START) state_d = StInit;
      StInit: state_d = (NUM != 11'd0) ? StRdLo : StWrLo;
      StRdLo: begin
        AVM_AVALONMASTER_READ    = 1'b1;
        AVM_AVALONMASTER_ADDRESS = rd_addr_q;
        if (xfer_done) state_d = StRdHi;
      end
      StRdHi: begin
        AVM_AVALONMASTER_READ    = 1'b1;
        AVM_AVALONMASTER_ADDRESS = rd_addr_q + AW'(4);
        if (xfer_done) state_d = last ? StWrLo : StRdLo;
      end
      StWrLo: begin
        AVM_AVALONMASTER_WRITE     = 1'b1;
        AVM_AVALONMASTER_ADDRESS   = res_addr_q;
        AVM_AVALONMASTER_WRITEDATA = peak_q[31:0];
        if (xfer_done) state_d = StWrHi;
      end
      StWrHi: begin
        AVM_AVALONMASTER_WRITE     = 1'b1;
        AVM_AVALONMASTER_ADDRESS   = res_addr_q + AW'(4);
        AVM_AVALONMASTER_WRITEDATA = peak_q[63:32];
        if (xfer_done) state_d = StWrIdx;
      end
      StWrIdx: begin
        AVM_AVALONMASTER_WRITE     = 1'b1;
        AVM_AVALONMASTER_ADDRESS   = res_addr_q + AW'(8);
        AVM_AVALONMASTER_WRITEDATA = {5'h0, above_q, 5'h0, peak_idx_q};
        if (xfer_done) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CSI_CLOCK_CLK or negedge CSI_CLOCK_RESET) begin
    if (!CSI_CLOCK_RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CSI_CLOCK_CLK or negedge CSI_CLOCK_RESET) begin
    if (!CSI_CLOCK_RESET) begin
      num_q      <= '0;
      idx_q      <= '0;
      peak_idx_q <= '0;
      above_q    <= '0;
      rd_addr_q  <= '0;
      res_addr_q <= '0;
      thresh_q   <= '0;
      peak_q     <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        StInit: begin
          num_q      <= NUM;
          rd_addr_q  <= MADDR;
          res_addr_q <= RESADDR;
          thresh_q   <= THRESH;
          idx_q      <= '0;
          peak_q     <= '0;
          peak_idx_q <= '0;
          above_q    <= '0;
        end
        StRdLo: if (xfer_done) lo_q <= AVM_AVALONMASTER_READDATA;
        StRdHi: begin
          if (xfer_done) begin
            // Strict compare keeps the first index on ties and never lets 0 win.
            if (mag > peak_q) begin
              peak_q     <= mag;
              peak_idx_q <= idx_q;
            end
            if (mag > thresh_q) above_q <= above_q + 11'd1;
            idx_q     <= idx_q + 11'd1;
            rd_addr_q <= rd_addr_q + AW'(8);
          end
        end
        default: ;
      endcase
    end
  end

  assign DONE       = (state_q == StFin);
  assign BUSY       = (state_q != StIdle);
  assign PEAK_VALUE = peak_q;
  assign PEAK_INDEX = peak_idx_q;
  assign ABOVE_CNT  = above_q;

endmodule
